if_id_stage: RTL and testbench

//   Pipeline register between instruction fetch and decode in the MIPS datapath.

---
 rtl/if_id_stage.sv | 125 ++++++++++++
 tb/tb_if_id_stage.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/if_id_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_id_stage
// Brief    : IF/ID pipeline register, two-entry skid buffer with field split.
// Revision : 1.0 - initial release
// ============================================================================
module if_id_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          PC_W      = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [PC_W-1:0] in_pc4,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [PC_W-1:0] out_pc4,
  output logic [5:0]      out_opcode,
  output logic [4:0]      out_rs,
  output logic [4:0]      out_rt,
  output logic [4:0]      out_rd,
  output logic [4:0]      out_shamt,
  output logic [5:0]      out_funct,
  output logic [15:0]     out_imm16,
  output logic [25:0]     out_jaddr
);

  localparam logic [1:0] S_EMPTY = 2'd0;
  localparam logic [1:0] S_ONE   = 2'd1;
  localparam logic [1:0] S_TWO   = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [31:0]     main_instr_q, main_instr_d;
  logic [PC_W-1:0] main_pc4_q, main_pc4_d;
  logic [31:0]     skid_instr_q, skid_instr_d;
  logic [PC_W-1:0] skid_pc4_q, skid_pc4_d;

  logic w_push;
  logic w_pop;

  // Handshake flags come from the state register only, keeping ready paths registered.
  assign in_ready  = (state_q != S_TWO);
  assign out_valid = (state_q != S_EMPTY);
  assign w_push    = in_valid & in_ready;
  assign w_pop     = out_valid & out_ready;

  always_comb begin
    state_d      = state_q;
    main_instr_d = main_instr_q;
    main_pc4_d   = main_pc4_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;
    if (flush) begin
      state_d      = S_EMPTY;
      main_instr_d = NOP_INSTR;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (w_push) begin
            state_d      = S_ONE;
            main_instr_d = in_instr;
            main_pc4_d   = in_pc4;
          end
        end
        S_ONE: begin
          if (w_push && !w_pop) begin
            state_d      = S_TWO;
            skid_instr_d = in_instr;
            skid_pc4_d   = in_pc4;
          end else if (w_push && w_pop) begin
            main_instr_d = in_instr;
            main_pc4_d   = in_pc4;
          end else if (w_pop) begin
            state_d      = S_EMPTY;
            main_instr_d = NOP_INSTR;
          end
        end
        S_TWO: begin
          if (w_pop) begin
            state_d      = S_ONE;
            main_instr_d = skid_instr_q;
            main_pc4_d   = skid_pc4_q;
          end
        end
        default: begin
          state_d      = S_EMPTY;
          main_instr_d = NOP_INSTR;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_EMPTY;
      main_instr_q <= NOP_INSTR;
      main_pc4_q   <= '0;
      skid_instr_q <= NOP_INSTR;
      skid_pc4_q   <= '0;
    end else begin
      state_q      <= state_d;
      main_instr_q <= main_instr_d;
      main_pc4_q   <= main_pc4_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
    end
  end

  assign out_instr  = main_instr_q;
  assign out_pc4    = main_pc4_q;
  assign out_opcode = main_instr_q[31:26];
  assign out_rs     = main_instr_q[25:21];
  assign out_rt     = main_instr_q[20:16];
  assign out_rd     = main_instr_q[15:11];
  assign out_shamt  = main_instr_q[10:6];
  assign out_funct  = main_instr_q[5:0];
  assign out_imm16  = main_instr_q[15:0];
  assign out_jaddr  = main_instr_q[25:0];

endmodule
`default_nettype wire

// File: tb/tb_if_id_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_id_stage
// Brief    : Directed and scoreboard bench for the IF/ID skid register.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_id_stage;

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam logic [31:0] A   = 32'h2001_0005;
  localparam logic [31:0] B   = 32'h2002_0006;
  localparam logic [31:0] C   = 32'h2003_0007;
  localparam logic [31:0] D   = 32'h2004_0008;
  localparam logic [31:0] E   = 32'h2005_0009;
  localparam logic [31:0] F   = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_instr, out_instr, in_pc4, out_pc4;
  logic [5:0]  out_opcode, out_funct;
  logic [4:0]  out_rs, out_rt, out_rd, out_shamt;
  logic [15:0] out_imm16;
  logic [25:0] out_jaddr;

  int n_pass  = 0;
  int n_total = 0;

  if_id_stage #(.NOP_INSTR(32'h0000_0000), .PC_W(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc4(in_pc4), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc4(out_pc4), .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt),
    .out_rd(out_rd), .out_shamt(out_shamt), .out_funct(out_funct),
    .out_imm16(out_imm16), .out_jaddr(out_jaddr)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs and samples both live 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; reset = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic fill_ab();
    out_ready = 1'b0; in_valid = 1'b1; in_instr = A; in_pc4 = 32'h100;
    step();
    in_instr = B; in_pc4 = 32'h104;
    step();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; in_valid = 1'b1; in_instr = F; in_pc4 = 32'h44; flush = 1'b0; out_ready = 1'b0;
    step(); step();
    reset = 1'b0; in_valid = 1'b0;
    n_total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", out_valid); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b want 1", in_ready); else n_pass++;
    n_total++; if (out_instr !== NOP) $display("FAIL reset_out_instr got %h want %h", out_instr, NOP); else n_pass++;
    n_total++; if (out_pc4 !== 32'h0) $display("FAIL reset_out_pc4 got %h want 0", out_pc4); else n_pass++;
  endtask

  task automatic test_stream();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; in_instr = 32'h8C22_FFFC; in_pc4 = 32'd4;
    step();
    n_total++; if (out_valid !== 1'b1) $display("FAIL stream_valid1 got %0b want 1", out_valid); else n_pass++;
    n_total++; if (out_opcode !== 6'h23) $display("FAIL stream_opcode got %h want 23", out_opcode); else n_pass++;
    n_total++; if (out_rs !== 5'd1) $display("FAIL stream_rs got %0d want 1", out_rs); else n_pass++;
    n_total++; if (out_rt !== 5'd2) $display("FAIL stream_rt got %0d want 2", out_rt); else n_pass++;
    n_total++; if (out_imm16 !== 16'hFFFC) $display("FAIL stream_imm16 got %h want fffc", out_imm16); else n_pass++;
    n_total++; if (out_pc4 !== 32'd4) $display("FAIL stream_pc4a got %0d want 4", out_pc4); else n_pass++;
    in_instr = 32'h0043_0820; in_pc4 = 32'd8;
    step();
    in_valid = 1'b0;
    n_total++; if (out_funct !== 6'h20) $display("FAIL stream_funct got %h want 20", out_funct); else n_pass++;
    n_total++; if (out_rd !== 5'd1) $display("FAIL stream_rd got %0d want 1", out_rd); else n_pass++;
    n_total++; if (out_rs !== 5'd2) $display("FAIL stream_rs2 got %0d want 2", out_rs); else n_pass++;
    n_total++; if (out_rt !== 5'd3) $display("FAIL stream_rt2 got %0d want 3", out_rt); else n_pass++;
    n_total++; if (out_jaddr !== 26'h043_0820) $display("FAIL stream_jaddr got %h want 0430820", out_jaddr); else n_pass++;
    n_total++; if (out_pc4 !== 32'd8) $display("FAIL stream_pc4b got %0d want 8", out_pc4); else n_pass++;
    step();
    n_total++; if (out_valid !== 1'b0) $display("FAIL stream_drain_valid got %0b want 0", out_valid); else n_pass++;
    n_total++; if (out_instr !== NOP) $display("FAIL stream_drain_nop got %h want %h", out_instr, NOP); else n_pass++;
  endtask

  task automatic test_backpressure();
    do_reset();
    fill_ab();
    n_total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready_full got %0b want 0", in_ready); else n_pass++;
    n_total++; if (out_instr !== A) $display("FAIL bp_head_a got %h want %h", out_instr, A); else n_pass++;
    step(); step();
    n_total++; if (out_instr !== A) $display("FAIL bp_stable_a got %h want %h", out_instr, A); else n_pass++;
    n_total++; if (out_pc4 !== 32'h100) $display("FAIL bp_stable_pc4 got %h want 100", out_pc4); else n_pass++;
    out_ready = 1'b1;
    step();
    n_total++; if (out_instr !== B) $display("FAIL bp_second_b got %h want %h", out_instr, B); else n_pass++;
    n_total++; if (out_pc4 !== 32'h104) $display("FAIL bp_second_pc4 got %h want 104", out_pc4); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL bp_in_ready_back got %0b want 1", in_ready); else n_pass++;
    step();
    n_total++; if (out_valid !== 1'b0) $display("FAIL bp_empty got %0b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_full_pop();
    logic [31:0] src [3];
    logic [31:0] want [5];
    logic [31:0] got [$];
    int idx;
    src[0] = C; src[1] = D; src[2] = E;
    want[0] = A; want[1] = B; want[2] = C; want[3] = D; want[4] = E;
    idx = 0;
    do_reset();
    fill_ab();
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 20 && got.size() < 5; cyc++) begin
      in_valid = (idx < 3);
      in_instr = (idx < 3) ? src[idx] : 32'h0;
      in_pc4   = 32'h200 + 32'(idx);
      if (out_valid && out_ready) got.push_back(out_instr);
      if (in_valid && in_ready) idx++;
      step();
    end
    in_valid = 1'b0;
    n_total++; if (got.size() != 5) $display("FAIL full_pop_count got %0d want 5", got.size()); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      n_total++;
      if (i >= got.size()) $display("FAIL full_pop_order[%0d] got none want %h", i, want[i]);
      else if (got[i] !== want[i]) $display("FAIL full_pop_order[%0d] got %h want %h", i, got[i], want[i]);
      else n_pass++;
    end
    n_total++; if (out_valid !== 1'b0) $display("FAIL full_pop_empty got %0b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_flush();
    do_reset();
    fill_ab();
    flush = 1'b1; in_valid = 1'b1; in_instr = F; in_pc4 = 32'h300; out_ready = 1'b0;
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL flush_valid got %0b want 0", out_valid); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL flush_ready got %0b want 1", in_ready); else n_pass++;
    n_total++; if (out_instr !== NOP) $display("FAIL flush_nop got %h want %h", out_instr, NOP); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      step();
      n_total++;
      if (out_valid !== 1'b0 || out_instr === F)
        $display("FAIL flush_no_f[%0d] got valid=%0b instr=%h want valid=0", i, out_valid, out_instr);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    fill_ab();
    reset = 1'b1;
    step();
    reset = 1'b0; out_ready = 1'b1;
    n_total++; if (out_valid !== 1'b0) $display("FAIL rstmid_valid got %0b want 0", out_valid); else n_pass++;
    n_total++; if (in_ready !== 1'b1) $display("FAIL rstmid_ready got %0b want 1", in_ready); else n_pass++;
    n_total++; if (out_instr !== NOP) $display("FAIL rstmid_instr got %h want %h", out_instr, NOP); else n_pass++;
  endtask

  task automatic test_random();
    logic [63:0] q [$];
    logic        m_push, m_pop;
    int          errs;
    errs = 0;
    do_reset();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 63) == 0);
      in_instr  = $urandom;
      in_pc4    = $urandom;
      n_total++;
      if (out_valid !== (q.size() > 0) || in_ready !== (q.size() < 2)) begin
        if (errs < 10) $display("FAIL rand_flags cyc=%0d got v=%0b r=%0b want v=%0b r=%0b",
                                cyc, out_valid, in_ready, q.size() > 0, q.size() < 2);
        errs++;
      end else if (q.size() > 0 && ({out_instr, out_pc4} !== q[0] ||
                   out_opcode !== q[0][63:58] || out_rs !== q[0][57:53] ||
                   out_rt !== q[0][52:48] || out_shamt !== q[0][42:38] || out_funct !== q[0][37:32])) begin
        if (errs < 10) $display("FAIL rand_head cyc=%0d got %h/%h want %h/%h",
                                cyc, out_instr, out_pc4, q[0][63:32], q[0][31:0]);
        errs++;
      end else if (q.size() == 0 && out_instr !== NOP) begin
        if (errs < 10) $display("FAIL rand_empty_nop cyc=%0d got %h want %h", cyc, out_instr, NOP);
        errs++;
      end else n_pass++;
      m_pop  = (q.size() > 0) && out_ready;
      m_push = in_valid && (q.size() < 2);
      if (m_pop) void'(q.pop_front());
      if (flush) q.delete();
      else if (m_push) q.push_back({in_instr, in_pc4});
      step();
    end
    idle();
  endtask

  initial begin
    idle();
    in_instr = 32'h0; in_pc4 = 32'h0;
    test_reset();
    test_stream();
    test_backpressure();
    test_full_pop();
    test_flush();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
